// File: rtl/hex_msg_pkg.sv
// Shared definitions for the HEX message scheduler: glyph codes, message
// ids, FSM state type and the message ROM (glyph lookup, length, static word).
package hex_msg_pkg;

  localparam logic [3:0] GLYPH_P     = 4'd0;
  localparam logic [3:0] GLYPH_L     = 4'd1;
  localparam logic [3:0] GLYPH_A     = 4'd2;
  localparam logic [3:0] GLYPH_Y     = 4'd3;
  localparam logic [3:0] GLYPH_N     = 4'd4;
  localparam logic [3:0] GLYPH_O     = 4'd5;
  localparam logic [3:0] GLYPH_T     = 4'd6;
  localparam logic [3:0] GLYPH_E     = 4'd7;
  localparam logic [3:0] GLYPH_BLANK = 4'd8;
  localparam logic [3:0] GLYPH_D     = 4'd9;

  localparam logic [15:0] BLANK4 = {4{GLYPH_BLANK}};

  localparam logic [1:0] MSG_PLAY   = 2'd0;
  localparam logic [1:0] MSG_NOTE   = 2'd1;
  localparam logic [1:0] MSG_DONE   = 2'd2;
  localparam logic [1:0] MSG_SCROLL = 2'd3;

  // Blanks shifted in after the last scrolled glyph to clear the display.
  localparam int SCROLL_PAD = 4;

  typedef enum logic [1:0] {IDLE, SHOW, SCROLL} state_t;

  // Glyph at position idx of message id; anything past the end is blank.
  function automatic logic [3:0] msg_glyph(input logic [1:0] id, input logic [3:0] idx);
    logic [3:0] g;
    g = GLYPH_BLANK;
    case (id)
      MSG_PLAY: case (idx)
        4'd0: g = GLYPH_P; 4'd1: g = GLYPH_L; 4'd2: g = GLYPH_A; 4'd3: g = GLYPH_Y;
        default: g = GLYPH_BLANK;
      endcase
      MSG_NOTE: case (idx)
        4'd0: g = GLYPH_N; 4'd1: g = GLYPH_O; 4'd2: g = GLYPH_T; 4'd3: g = GLYPH_E;
        default: g = GLYPH_BLANK;
      endcase
      MSG_DONE: case (idx)
        4'd0: g = GLYPH_D; 4'd1: g = GLYPH_O; 4'd2: g = GLYPH_N; 4'd3: g = GLYPH_E;
        default: g = GLYPH_BLANK;
      endcase
      default: case (idx)
        4'd0: g = GLYPH_P; 4'd1: g = GLYPH_L; 4'd2: g = GLYPH_A; 4'd3: g = GLYPH_Y;
        4'd4: g = GLYPH_BLANK;
        4'd5: g = GLYPH_N; 4'd6: g = GLYPH_O; 4'd7: g = GLYPH_T; 4'd8: g = GLYPH_E;
        default: g = GLYPH_BLANK;
      endcase
    endcase
    return g;
  endfunction

  function automatic logic [3:0] msg_len(input logic [1:0] id);
    return (id == MSG_SCROLL) ? 4'd9 : 4'd4;
  endfunction

  // Four-glyph word for a static message, leftmost glyph in the top nibble.
  function automatic logic [15:0] msg_word(input logic [1:0] id);
    return {msg_glyph(id, 4'd0), msg_glyph(id, 4'd1), msg_glyph(id, 4'd2), msg_glyph(id, 4'd3)};
  endfunction

endpackage

// File: rtl/hex_msg_scheduler_tick_gen.sv
// Free-running display-tick prescaler.
//   clk, rst : clock, async active-high reset
//   clr      : restart count from 0 (wins over wrap)
//   tick     : high for one cycle when count == TICK_DIV-1
module tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/hex_msg_scheduler.sv
// Four-digit HEX message sequencer. Shows static words or scrolls a phrase
// right-to-left on a divided-down tick.
//   clk, rst       : clock, async active-high reset
//   msg_valid/id   : request, accepted when msg_valid && msg_ready
//   msg_ready      : low only while scrolling
//   digits         : glyph codes, [15:12] leftmost ... [3:0] rightmost
//   busy           : state != IDLE
//   done           : one-cycle pulse on natural return to IDLE
module hex_msg_scheduler
  import hex_msg_pkg::*;
#(
  parameter int TICK_DIV   = 12_500_000,
  parameter int HOLD_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msg_valid,
  input  logic [1:0]  msg_id,
  output logic        msg_ready,
  output logic [15:0] digits,
  output logic        busy,
  output logic        done
);
  localparam logic [3:0] SCROLL_LAST = 4'(int'(msg_len(MSG_SCROLL)) + SCROLL_PAD - 1);

  state_t      state, state_nxt;
  logic        tick, accept, hold_done, scroll_done;
  logic [31:0] hold_cnt, hold_nxt;
  logic [3:0]  scroll_cnt, scroll_nxt;
  logic [15:0] digits_nxt;

  assign accept = msg_valid && msg_ready;

  // The accept also restarts the prescaler, so a coincident tick is dropped.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  assign hold_done   = (HOLD_TICKS != 0) && tick && (hold_cnt == 32'(HOLD_TICKS - 1));
  assign scroll_done = tick && (scroll_cnt == SCROLL_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = (msg_id == MSG_SCROLL) ? SCROLL : SHOW;
    else case (state)
      SHOW:    if (hold_done)   state_nxt = IDLE;
      SCROLL:  if (scroll_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    digits_nxt = digits;
    hold_nxt   = hold_cnt;
    scroll_nxt = scroll_cnt;
    if (accept) begin
      hold_nxt   = '0;
      scroll_nxt = '0;
      digits_nxt = (msg_id == MSG_SCROLL) ? BLANK4 : msg_word(msg_id);
    end else case (state)
      SHOW: begin
        if (hold_done) begin
          digits_nxt = BLANK4;
          hold_nxt   = '0;
        end else if (tick) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      SCROLL: begin
        if (tick) begin
          // Glyph lookup past the phrase end yields blank, which clears the display.
          digits_nxt = {digits[11:0], msg_glyph(MSG_SCROLL, scroll_cnt)};
          scroll_nxt = scroll_done ? 4'd0 : scroll_cnt + 1'b1;
        end
      end
      default: digits_nxt = BLANK4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits     <= BLANK4;
      hold_cnt   <= '0;
      scroll_cnt <= '0;
      msg_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      digits     <= digits_nxt;
      hold_cnt   <= hold_nxt;
      scroll_cnt <= scroll_nxt;
      msg_ready  <= (state_nxt != SCROLL);
      busy       <= (state_nxt != IDLE);
      // Replacement never passes through IDLE, so it cannot pulse done.
      done       <= (state != IDLE) && (state_nxt == IDLE);
    end
  end
endmodule

// File: doc/hex_msg_scheduler.md
# hex_msg_scheduler

Sequencer that drives the four-digit HEX message display. It accepts message requests from the game/playback logic through a valid/ready handshake, then shows a short word statically or scrolls a longer phrase right-to-left on a divided-down tick. It outputs four 4-bit glyph codes, one per digit. Each code feeds an existing 7-segment glyph decoder instance, which is instantiated outside this block.

## Interface
- TICK_DIV, 12_500_000: clk cycles per display tick (4 Hz at 50 MHz); min 2
- HOLD_TICKS, 8: ticks a static message stays up; 0 = hold until replaced
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- msg_valid  in  1  request strobe; held until accepted
- msg_id  in  2  message select (see Operation)
- msg_ready  out  1  request accepted when msg_valid && msg_ready
- digits  out  16  glyph codes; [15:12] leftmost (HEX3) … [3:0] rightmost (HEX0)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on return to IDLE

## Operation
- Glyph codes: P=0, L=1, A=2, y=3, n=4, O=5, t=6, E=7, blank=8, D=9. Codes 10-15 are never driven.
- Message table:
  - id0 "PLAy" (0,1,2,3), static
  - id1 "nOtE" (4,5,6,7), static
  - id2 "DOnE" (9,5,4,7), static
  - id3 "PLAy nOtE" (0,1,2,3,8,4,5,6,7), length 9, scrolled
- States:
  - IDLE: digits all blank, msg_ready=1. Accepting a static id goes to SHOW; accepting id3 goes to SCROLL.
  - SHOW: digits = message, msg_ready=1. On each tick the hold counter increments. When it reaches HOLD_TICKS (if non-zero), go to IDLE.
  - SHOW with a new accept: load the new message (static, or scroll via id3) and restart the hold counter and prescaler.
  - SCROLL: msg_ready=0. The display starts at 16'h8888. Each tick shifts digits left by one glyph and inserts the next message glyph at [3:0]. After the last glyph, 4 blanks are inserted. After 9+4=13 ticks the display is blank, and the block goes to IDLE.
- done asserts in the first IDLE cycle after SHOW-timeout or SCROLL-complete. It never asserts on replacement or reset.
- Prescaler is free-running 0..TICK_DIV-1; tick=1 when count==TICK_DIV-1. It clears to 0 on every accept.
- Reset (asynchronous, any state, mid-scroll included):
  - state=IDLE, digits=16'h8888, msg_ready=1, busy=0, done=0
  - prescaler, hold and scroll counters cleared

## Timing
- Accept at edge E:
  - Static: digits hold the message from E+1.
  - Scroll: digits are 16'h8888 from E+1.
- First tick at E+TICK_DIV; the resulting digit change is visible one cycle after each tick.
- Static timeout: digits blank and done=1 at E+HOLD_TICKS·TICK_DIV+1.
- Scroll: 13 ticks, with done at E+13·TICK_DIV+1.
- A request that is pending while msg_ready=0 is accepted on the done cycle, since IDLE has msg_ready=1. That request sees at most one blank cycle.
- A tick coinciding with an accept is ignored (the accept wins).
- All outputs are registered.

## Structure
- Package hex_msg_pkg holds:
  - glyph constants GLYPH_P…GLYPH_D, GLYPH_BLANK=8
  - message id constants
  - state enum {IDLE, SHOW, SCROLL}
  - message ROM function (id, index → glyph) and length function
- Sub-module tick_gen is the prescaler, with ports clk, rst, clr, tick and parameter TICK_DIV.

## Test plan
All scenarios use TICK_DIV=4 and HOLD_TICKS=2.
- Reset: digits=16'h8888, msg_ready=1, busy=0, done=0.
- Static id0 accepted at edge 0 → digits=16'h0123 from cycle 1; 16'h8888 with a done pulse at cycle 9; busy low from cycle 9.
- Scroll id3 → on successive ticks digits = 8880, 8801, 8012, 0123, 1238, 2384, 3845, 8456, 4567, 5678, 6788, 7888, 8888. done fires once, and msg_ready=0 throughout.
- id0 showing, id2 requested at cycle 5 → 16'h9547 at cycle 6; blank and done at cycle 5+8+1=14; no done for id0.
- id1 held valid during id3 scroll → not accepted until the done cycle; then 16'h4567 on the next cycle.
- rst asserted mid-scroll between clock edges → digits=16'h8888 immediately; no done pulse; a fresh id0 after release behaves as in scenario 2.
